// File: rtl/cv32e40p_retire_trace_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cv32e40p_retire_trace_buffer_if                                 |
// | Brief    : Drain-side valid/ready port of the retirement trace buffer.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cv32e40p_retire_trace_buffer_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_wdata;

  modport master (
    output out_valid, out_pc, out_instr, out_wdata,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_instr, out_wdata,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_retire_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cv32e40p_retire_trace_buffer                                    |
// | Brief    : Circular retirement trace buffer, stop or overwrite-oldest mode. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cv32e40p_retire_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 2,
  parameter int OVERWRITE = 0,
  parameter int DATA_W    = 32
) (
  input  wire                         clk_i,
  input  wire                         rst_i,
  input  wire                         enable_i,
  input  wire                         clear_i,
  input  wire  [NUM_CH-1:0]           ch_valid_i,
  input  wire  [NUM_CH*DATA_W-1:0]    ch_pc_i,
  input  wire  [NUM_CH*DATA_W-1:0]    ch_instr_i,
  input  wire  [NUM_CH*DATA_W-1:0]    ch_wdata_i,
  cv32e40p_retire_trace_buffer_if.master out_if,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o,
  output logic [15:0]                 drop_cnt_o
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = 3 * DATA_W;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [c_EW-1:0] mem_q [DEPTH];
  logic [c_EW-1:0] mem_d [DEPTH];
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_CW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic              pop;
  logic [NUM_CH-1:0] push_vld;
  logic [c_CW-1:0]   free;
  logic [c_CW-1:0]   n_acc;
  logic [c_CW-1:0]   n_drop;
  logic [c_CW-1:0]   level;
  logic [c_CW-1:0]   excess;
  logic [16:0]       drop_sum;

  always_comb begin
    pop      = (count_q != '0) && out_if.out_ready;
    push_vld = ch_valid_i & {NUM_CH{enable_i}};
    free     = c_DEPTH - count_q + c_CW'(pop);
    n_acc    = '0;
    n_drop   = '0;
    mem_d    = mem_q;
    // Accepted events are packed into consecutive slots in channel order.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (push_vld[ch]) begin
        if ((OVERWRITE != 0) || (n_acc < free)) begin
          mem_d[wr_ptr_q + c_PW'(n_acc)] = {ch_pc_i[ch*DATA_W +: DATA_W],
                                            ch_instr_i[ch*DATA_W +: DATA_W],
                                            ch_wdata_i[ch*DATA_W +: DATA_W]};
          n_acc = n_acc + c_CW'(1);
        end else begin
          n_drop = n_drop + c_CW'(1);
        end
      end
    end
    // DEPTH + NUM_CH always fits in c_CW bits since DEPTH >= 4.
    level  = count_q - c_CW'(pop) + n_acc;
    excess = '0;
    if ((OVERWRITE != 0) && (level > c_DEPTH)) begin
      excess = level - c_DEPTH;
    end
    n_drop     = n_drop + excess;
    count_d    = level - excess;
    rd_ptr_d   = rd_ptr_q + c_PW'(pop) + c_PW'(excess);
    wr_ptr_d   = wr_ptr_q + c_PW'(n_acc);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (n_drop != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
    mem_q <= mem_d;
  end

  assign out_if.out_valid = (count_q != '0);
  assign {out_if.out_pc, out_if.out_instr, out_if.out_wdata} = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_retire_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cv32e40p_retire_trace_buffer                                 |
// | Brief    : Directed + scoreboard bench, stop and overwrite instances.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cv32e40p_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam logic [31:0] c_IOFF = 32'h1000_0000;
  localparam logic [31:0] c_WOFF = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst, enable, clear, rdy;
  logic [1:0]  ch_valid;
  logic [63:0] ch_pc, ch_instr, ch_wdata;
  logic [4:0]  cnt_s, cnt_o;
  logic        ovf_s, ovf_o;
  logic [15:0] drop_s, drop_o;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cv32e40p_retire_trace_buffer_if #(.DATA_W(32)) if_s ();
  cv32e40p_retire_trace_buffer_if #(.DATA_W(32)) if_o ();
  assign if_s.out_ready = rdy;
  assign if_o.out_ready = rdy;

  cv32e40p_retire_trace_buffer #(.DEPTH(DEPTH), .NUM_CH(2), .OVERWRITE(0), .DATA_W(32)) dut_s (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .ch_valid_i(ch_valid), .ch_pc_i(ch_pc), .ch_instr_i(ch_instr), .ch_wdata_i(ch_wdata),
    .out_if(if_s), .count_o(cnt_s), .overflow_o(ovf_s), .drop_cnt_o(drop_s)
  );

  cv32e40p_retire_trace_buffer #(.DEPTH(DEPTH), .NUM_CH(2), .OVERWRITE(1), .DATA_W(32)) dut_o (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .ch_valid_i(ch_valid), .ch_pc_i(ch_pc), .ch_instr_i(ch_instr), .ch_wdata_i(ch_wdata),
    .out_if(if_o), .count_o(cnt_o), .overflow_o(ovf_o), .drop_cnt_o(drop_o)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        rdy;
    logic        clr;
    logic        en;
    logic [4:0]  cnt;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    ch_valid = v;
    ch_pc    = {p1, p0};
    ch_instr = {p1 + c_IOFF, p0 + c_IOFF};
    ch_wdata = {p1 + c_WOFF, p0 + c_WOFF};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel=0: stop-mode instance, sel=1: overwrite-mode instance
  task automatic chk_dut(input string name, input bit sel, input logic [4:0] cnt,
                         input logic vld, input logic [31:0] pc,
                         input logic [15:0] drp, input logic ovf);
    logic [4:0]  a_cnt;
    logic        a_vld, a_ovf;
    logic [31:0] a_pc, a_ins, a_wd;
    logic [15:0] a_drp;
    a_cnt = sel ? cnt_o : cnt_s;
    a_vld = sel ? if_o.out_valid : if_s.out_valid;
    a_pc  = sel ? if_o.out_pc : if_s.out_pc;
    a_ins = sel ? if_o.out_instr : if_s.out_instr;
    a_wd  = sel ? if_o.out_wdata : if_s.out_wdata;
    a_drp = sel ? drop_o : drop_s;
    a_ovf = sel ? ovf_o : ovf_s;
    chk({name, sel ? ".o.count" : ".s.count"}, 32'(a_cnt), 32'(cnt));
    chk({name, sel ? ".o.valid" : ".s.valid"}, 32'(a_vld), 32'(vld));
    chk({name, sel ? ".o.drop" : ".s.drop"}, 32'(a_drp), 32'(drp));
    chk({name, sel ? ".o.ovf" : ".s.ovf"}, 32'(a_ovf), 32'(ovf));
    if (vld) begin
      chk({name, sel ? ".o.pc" : ".s.pc"}, a_pc, pc);
      chk({name, sel ? ".o.instr" : ".s.instr"}, a_ins, pc + c_IOFF);
      chk({name, sel ? ".o.wdata" : ".s.wdata"}, a_wd, pc + c_WOFF);
    end
  endtask

  task automatic clr_pulse();
    rdy   = 1'b0;
    clear = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    step();
    clear = 1'b0;
  endtask

  logic [31:0] q_s [$];
  logic [31:0] q_o [$];
  int          ds, dov, pushed, fs;
  logic [31:0] pcn, p0, p1;
  logic [1:0]  rv;
  logic        rr;

  initial begin
    tbl[0] = '{2'b11, 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'h100};
    tbl[1] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 32'h104};
    tbl[2] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0};
    tbl[3] = '{2'b01, 32'h200, 32'h0,   1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0};
    tbl[4] = '{2'b10, 32'h0,   32'h300, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h300};
    tbl[5] = '{2'b11, 32'h304, 32'h308, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'h304};
    tbl[6] = '{2'b01, 32'h30C, 32'h0,   1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0};
    tbl[7] = '{2'b01, 32'h400, 32'h0,   1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h400};
    tbl[8] = '{2'b00, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h400};
    tbl[9] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0};

    rst = 1'b1; enable = 1'b1; clear = 1'b0; rdy = 1'b0;
    drive(2'b11, 32'h900, 32'h904);
    step();
    step();
    chk_dut("reset", 1'b0, 5'd0, 1'b0, 32'h0, 16'h0, 1'b0);
    chk_dut("reset", 1'b1, 5'd0, 1'b0, 32'h0, 16'h0, 1'b0);
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].pc0, tbl[i].pc1);
      rdy    = tbl[i].rdy;
      clear  = tbl[i].clr;
      enable = tbl[i].en;
      step();
      chk_dut($sformatf("vec%0d", i), 1'b0, tbl[i].cnt, tbl[i].vld, tbl[i].pc, 16'h0, 1'b0);
      chk_dut($sformatf("vec%0d", i), 1'b1, tbl[i].cnt, tbl[i].vld, tbl[i].pc, 16'h0, 1'b0);
    end
    clear = 1'b0; enable = 1'b1;

    // Full buffer: 18 events into 16 entries
    clr_pulse();
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k));
      step();
    end
    drive(2'b00, 32'h0, 32'h0);
    chk_dut("full", 1'b0, 5'd16, 1'b1, 32'h100, 16'd2, 1'b1);
    chk_dut("full", 1'b1, 5'd16, 1'b1, 32'h108, 16'd2, 1'b1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.s.pc", k), if_s.out_pc, 32'h100 + 32'(4*k));
      chk($sformatf("drain%0d.o.pc", k), if_o.out_pc, 32'h108 + 32'(4*k));
      rdy = 1'b1;
      step();
    end
    rdy = 1'b0;
    chk_dut("drained", 1'b0, 5'd0, 1'b0, 32'h0, 16'd2, 1'b1);
    chk_dut("drained", 1'b1, 5'd0, 1'b0, 32'h0, 16'd2, 1'b1);

    // Clear wins over a push in the same cycle
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, 32'h700 + 32'(8*k), 32'h704 + 32'(8*k));
      step();
    end
    clear = 1'b1;
    drive(2'b11, 32'h800, 32'h804);
    step();
    clear = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    chk_dut("clrpush", 1'b0, 5'd0, 1'b0, 32'h0, 16'd0, 1'b0);
    chk_dut("clrpush", 1'b1, 5'd0, 1'b0, 32'h0, 16'd0, 1'b0);

    // Push and pop together while full
    clr_pulse();
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 32'h500 + 32'(8*k), 32'h504 + 32'(8*k));
      step();
    end
    chk_dut("fill16", 1'b0, 5'd16, 1'b1, 32'h500, 16'd0, 1'b0);
    chk_dut("fill16", 1'b1, 5'd16, 1'b1, 32'h500, 16'd0, 1'b0);
    rdy = 1'b1;
    drive(2'b01, 32'h540, 32'h544);
    step();
    drive(2'b00, 32'h0, 32'h0);
    chk_dut("pushpop", 1'b0, 5'd16, 1'b1, 32'h504, 16'd0, 1'b0);
    chk_dut("pushpop", 1'b1, 5'd16, 1'b1, 32'h504, 16'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("pp%0d.s.pc", k), if_s.out_pc, 32'h504 + 32'(4*k));
      chk($sformatf("pp%0d.o.pc", k), if_o.out_pc, 32'h504 + 32'(4*k));
      step();
    end
    chk("pp.s.empty", 32'(cnt_s), 32'd0);

    // Random stream against queue models, many pointer wraps
    clr_pulse();
    ds = 0; dov = 0; pushed = 0; pcn = 32'h0001_0000;
    for (int cyc = 0; cyc < 4000 && pushed < 1000; cyc++) begin
      rv  = 2'($urandom);
      rr  = 1'($urandom_range(0, 1));
      p0  = pcn;
      p1  = pcn + 32'd4;
      pcn = pcn + 32'd8;
      pushed += int'(rv[0]) + int'(rv[1]);
      rdy = rr;
      drive(rv, p0, p1);
      if (q_s.size() > 0 && rr) void'(q_s.pop_front());
      fs = DEPTH - q_s.size();
      if (rv[0]) begin if (fs > 0) begin q_s.push_back(p0); fs--; end else ds++; end
      if (rv[1]) begin if (fs > 0) begin q_s.push_back(p1); fs--; end else ds++; end
      if (q_o.size() > 0 && rr) void'(q_o.pop_front());
      if (rv[0]) q_o.push_back(p0);
      if (rv[1]) q_o.push_back(p1);
      while (q_o.size() > DEPTH) begin void'(q_o.pop_front()); dov++; end
      step();
      chk("rnd.s.count", 32'(cnt_s), 32'(q_s.size()));
      chk("rnd.o.count", 32'(cnt_o), 32'(q_o.size()));
      if (q_s.size() > 0) begin
        chk("rnd.s.pc", if_s.out_pc, q_s[0]);
        chk("rnd.s.wdata", if_s.out_wdata, q_s[0] + c_WOFF);
      end
      if (q_o.size() > 0) chk("rnd.o.pc", if_o.out_pc, q_o[0]);
    end
    chk("rnd.pushed", 32'(pushed >= 1000), 32'd1);
    chk("rnd.s.drop", 32'(drop_s), 32'(ds));
    chk("rnd.o.drop", 32'(drop_o), 32'(dov));

    // Drop counter saturation: 8 cycles fill, then 2 drops per cycle
    clr_pulse();
    drive(2'b11, 32'hA00, 32'hA04);
    for (int k = 0; k < 1000; k++) step();
    chk("sat.mid.s", 32'(drop_s), 32'd1984);
    chk("sat.mid.o", 32'(drop_o), 32'd1984);
    for (int k = 0; k < 34000; k++) step();
    chk_dut("sat", 1'b0, 5'd16, 1'b1, 32'hA00, 16'hFFFF, 1'b1);
    chk_dut("sat", 1'b1, 5'd16, 1'b1, 32'hA00, 16'hFFFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
